// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM states, stage tag
// layout, and the NOP tag loaded on bubbles and invalid EX slots.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, REDIRECT} state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_we;
    logic       mem_rr;
    logic       mem_we;
  } tag_t;

  localparam logic [4:0] REG_X0  = 5'd0;
  localparam tag_t       NOP_TAG = '{rd: REG_X0, reg_we: 1'b0, mem_rr: 1'b0, mem_we: 1'b0};

  // x0 is never written, so a write tag aimed at it is dropped on capture
  function automatic tag_t sanitize(input tag_t t);
    tag_t r;
    r = t;
    if (t.rd == REG_X0) r.reg_we = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/pipe_tag_reg.sv
// One pipeline stage tag register with hold and NOP-insert controls.
module pipe_tag_reg
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_hold,
  input  logic i_nop,
  input  tag_t i_d,
  output tag_t o_q
);

  tag_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= NOP_TAG;
    else if (!i_hold) r_q <= i_nop ? NOP_TAG : sanitize(i_d);
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller with MEM and WB tag slots.
// Optional PIPE_CTRL_PERF_EN adds stall_cycles / flush_count counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_reg_we,
  input  logic        ex_mem_rr,
  input  logic        ex_mem_we,
  input  logic [4:0]  ex_rd,
  input  logic        bubble,
  input  logic        do_jump,
  input  logic        dmem_ready,
  output logic [4:0]  prev_rd,
  output logic [4:0]  wb_rd,
  output logic        prev_reg_we,
  output logic        prev_mem_rr,
  output logic        wb_reg_we,
  output logic        wb_mem_rr,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        pc_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        if_flush,
  output logic        id_flush
);

  state_e r_state, w_state_nxt;
  tag_t   w_ex_tag, w_mem, w_wb;
  logic   w_mem_busy, w_jump_acc;
  logic   w_unused_wb_mem_we;

  assign w_ex_tag   = ex_valid ? '{rd: ex_rd, reg_we: ex_reg_we, mem_rr: ex_mem_rr, mem_we: ex_mem_we}
                               : NOP_TAG;
  assign w_mem_busy = (w_mem.mem_rr | w_mem.mem_we) & ~dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // Priority: memory wait, then load-use bubble, then jump redirect.
  always_comb begin
    w_state_nxt = RUN;
    pc_stall    = 1'b0;
    id_stall    = 1'b0;
    ex_stall    = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    w_jump_acc  = 1'b0;
    if (!rst_n) begin
      w_state_nxt = RUN;
    end else if (w_mem_busy) begin
      pc_stall    = 1'b1;
      id_stall    = 1'b1;
      ex_stall    = 1'b1;
      w_state_nxt = MEM_WAIT;
    end else if (bubble) begin
      pc_stall    = 1'b1;
      id_stall    = 1'b1;
      if_flush    = (r_state == REDIRECT);
      w_state_nxt = LOAD_STALL;
    end else if (do_jump) begin
      if_flush    = 1'b1;
      id_flush    = 1'b1;
      w_jump_acc  = 1'b1;
      w_state_nxt = REDIRECT;
    end else begin
      if_flush    = (r_state == REDIRECT);
      w_state_nxt = RUN;
    end
  end

  pipe_tag_reg u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_hold (w_mem_busy),
    .i_nop  (bubble),
    .i_d    (w_ex_tag),
    .o_q    (w_mem)
  );

  pipe_tag_reg u_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_hold (w_mem_busy),
    .i_nop  (1'b0),
    .i_d    (w_mem),
    .o_q    (w_wb)
  );

  assign prev_rd     = w_mem.rd;
  assign prev_reg_we = w_mem.reg_we;
  assign prev_mem_rr = w_mem.mem_rr;
  assign wb_rd       = w_wb.rd;
  assign wb_reg_we   = w_wb.reg_we;
  assign wb_mem_rr   = w_wb.mem_rr;
  // Stores are finished by WB; their flag is carried but not consumed.
  assign w_unused_wb_mem_we = w_wb.mem_we;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles, r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (pc_stall)   r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_jump_acc) r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ex_valid = 0, ex_reg_we = 0, ex_mem_rr = 0, ex_mem_we = 0;
  logic [4:0] ex_rd = '0;
  logic       bubble = 0, do_jump = 0, dmem_ready = 1;
  logic [4:0] prev_rd, wb_rd;
  logic       prev_reg_we, prev_mem_rr, wb_reg_we, wb_mem_rr;
  logic       pc_stall, id_stall, ex_stall, if_flush, id_flush;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_reg_we(ex_reg_we), .ex_mem_rr(ex_mem_rr), .ex_mem_we(ex_mem_we),
    .ex_rd(ex_rd), .bubble(bubble), .do_jump(do_jump), .dmem_ready(dmem_ready),
    .prev_rd(prev_rd), .wb_rd(wb_rd), .prev_reg_we(prev_reg_we), .prev_mem_rr(prev_mem_rr),
    .wb_reg_we(wb_reg_we), .wb_mem_rr(wb_mem_rr),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .pc_stall(pc_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .if_flush(if_flush), .id_flush(id_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [18:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 1'b0;

  function automatic logic [18:0] act_vec();
    return {pc_stall, id_stall, ex_stall, if_flush, id_flush,
            prev_rd, prev_reg_we, prev_mem_rr, wb_rd, wb_reg_we, wb_mem_rr};
  endfunction

  // st = {pc,id,ex,if_flush,id_flush}; pv/wb = {rd,reg_we,mem_rr}
  task automatic step(input string nm, input logic rst,
                      input logic v, input logic we, input logic rr, input logic mw,
                      input logic [4:0] rd, input logic bub, input logic jmp, input logic rdy,
                      input logic [4:0] st, input logic [6:0] pv, input logic [6:0] wb);
    @(posedge clk); #1;
    rst_n = rst;
    ex_valid = v; ex_reg_we = we; ex_mem_rr = rr; ex_mem_we = mw; ex_rd = rd;
    bubble = bub; do_jump = jmp; dmem_ready = rdy;
    q.push_back('{nm, {st, pv, wb}});
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [18:0] a;
      e = q.pop_front();
      a = act_vec();
      n_checks++;
      if (a === e.exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", e.name, a, e.exp);
    end
  end

  initial begin
    //        name       rst v we rr mw rd    bub jmp rdy  st        pv              wb
    step("reset_hold",   0, 1, 1, 1, 0, 5'd5, 1, 1, 1, 5'b00000, 7'd0,           7'd0);
    step("load_x5",      1, 1, 1, 1, 0, 5'd5, 0, 0, 1, 5'b00000, 7'd0,           7'd0);
    step("bubble",       1, 1, 1, 0, 0, 5'd6, 1, 0, 1, 5'b11000, {5'd5, 2'b11},  7'd0);
    step("after_bubble", 1, 1, 1, 0, 0, 5'd6, 0, 0, 1, 5'b00000, 7'd0,           {5'd5, 2'b11});
    step("x0_write",     1, 1, 1, 0, 0, 5'd0, 0, 0, 1, 5'b00000, {5'd6, 2'b10},  7'd0);
    step("x0_dropped",   1, 0, 1, 0, 0, 5'd7, 0, 0, 1, 5'b00000, 7'd0,           {5'd6, 2'b10});
    step("jump",         1, 1, 1, 0, 0, 5'd8, 0, 1, 1, 5'b00011, 7'd0,           7'd0);
    step("redirect_ext", 1, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00010, {5'd8, 2'b10},  7'd0);
    step("run_again",    1, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000, 7'd0,           {5'd8, 2'b10});
    step("jump2",        1, 0, 0, 0, 0, 5'd0, 0, 1, 1, 5'b00011, 7'd0,           7'd0);
    step("jump_in_redir",1, 0, 0, 0, 0, 5'd0, 0, 1, 1, 5'b00011, 7'd0,           7'd0);
    step("redir_restart",1, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00010, 7'd0,           7'd0);
    step("redir_done",   1, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000, 7'd0,           7'd0);
    step("load_x9",      1, 1, 1, 1, 0, 5'd9, 0, 0, 1, 5'b00000, 7'd0,           7'd0);
    for (int i = 0; i < 3; i++)
      step("mem_wait",   1, 1, 1, 0, 0, 5'd10, 1, 1, 0, 5'b11100, {5'd9, 2'b11}, 7'd0);
    step("mem_release",  1, 1, 1, 0, 0, 5'd10, 0, 0, 1, 5'b00000, {5'd9, 2'b11}, 7'd0);
    step("mem_advance",  1, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000, {5'd10, 2'b10}, {5'd9, 2'b11});
    step("store",        1, 1, 0, 0, 1, 5'd0, 0, 0, 1, 5'b00000, 7'd0,           {5'd10, 2'b10});
    step("store_wait",   1, 0, 0, 0, 0, 5'd0, 0, 0, 0, 5'b11100, 7'd0,           7'd0);
    step("store_done",   1, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000, 7'd0,           7'd0);
    step("jump3",        1, 1, 1, 0, 0, 5'd11, 0, 1, 1, 5'b00011, 7'd0,          7'd0);
    step("reset_redir",  0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000, 7'd0,           7'd0);
    step("post_reset",   1, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000, 7'd0,           7'd0);
    step("bub_over_jmp", 1, 1, 1, 0, 0, 5'd12, 1, 1, 1, 5'b11000, 7'd0,          7'd0);
    step("idle",         1, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000, 7'd0,           7'd0);
`ifdef PIPE_CTRL_PERF_EN
    step("perf_reset",   0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000, 7'd0,           7'd0);
    step("perf_stall1",  1, 0, 0, 0, 0, 5'd0, 1, 0, 1, 5'b11000, 7'd0,           7'd0);
    step("perf_stall2",  1, 0, 0, 0, 0, 5'd0, 1, 0, 1, 5'b11000, 7'd0,           7'd0);
    step("perf_jump",    1, 0, 0, 0, 0, 5'd0, 0, 1, 1, 5'b00011, 7'd0,           7'd0);
    step("perf_ext",     1, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00010, 7'd0,           7'd0);
    step("perf_idle",    1, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000, 7'd0,           7'd0);
    @(negedge clk); #1;
    n_checks++;
    if (stall_cycles === 32'd2) n_pass++;
    else $display("FAIL stall_cycles: got %0d expected 2", stall_cycles);
    n_checks++;
    if (flush_count === 32'd1) n_pass++;
    else $display("FAIL flush_count: got %0d expected 1", flush_count);
`endif
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
